alu_pipe_hs: RTL
================

// Module: alu_pipe_hs
// PURPOSE
//  Parametrised-width ALU with valid/ready handshakes on input and output. It has a
//  registered result, carry/zero/overflow/error flags and a multi-cycle shift-subtract divider.
//  It sits between the register-file/command controller and the UART TX framer, and
//  replaces the enable-only fixed-width ALU. Backpressure from the TX path stalls
//  issue; it does not drop results.
// PARAMETERS
//  WIDTH   8  operand width in bits; the result is 2*WIDTH bits
//  DIV_EN  1  1 = iterative divider built; 0 = DIV returns err=1, ALU_OUT=0, latency 1
// PORTS
//  CLK        in   1        clock, all state on rising edge
//  RST        in   1        asynchronous, active-high reset
//  in_valid   in   1        operands/opcode valid
//  in_ready   out  1        block can accept an operation this cycle
//  A, B       in   WIDTH    operands (unsigned unless noted)
//  ALU_FUN    in   4        opcode: [3:2] unit, [1:0] function
//  out_valid  out  1        ALU_OUT and flags valid
//  out_ready  in   1        consumer accepts the result
//  ALU_OUT    out  2*WIDTH  result
//  carry      out  1        ADD carry-out / SUB borrow
//  ovf        out  1        signed overflow (ADD/SUB only)
//  zero       out  1        ALU_OUT == 0
//  err        out  1        divide by zero, or DIV with DIV_EN=0
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, ALU_OUT, carry, ovf, zero, err all 0; in_ready=0 while RST=1.
//   RST asserted mid-divide aborts the divide and discards its result.
//  Accept: an operation is accepted on the edge where in_valid & in_ready = 1.
//   in_ready = (state==IDLE) & (!out_valid | out_ready) = one-deep output register.
//   in_ready is combinational from out_ready and state, with no path from in_valid.
//  Output: the result is consumed on the edge where out_valid & out_ready = 1.
//   While out_valid=1 and out_ready=0, ALU_OUT and all flags are held stable.
//   Accept and consume in the same cycle are legal; out_valid stays 1 with the new result.
//  Latency: 1 cycle for all ops except DIV, which takes WIDTH+1 cycles (accept -> out_valid).
//  FSM IDLE -> DIV on accept of DIV with B!=0 and DIV_EN=1.
//   In DIV, a counter runs WIDTH iterations of restoring shift-subtract, then the FSM goes to IDLE.
//   The result is loaded and out_valid set on that final transition; in_ready=0 throughout DIV.
//  Opcodes:
//   0000 ADD: ALU_OUT = {0, A+B} (WIDTH+1 bits, zero-extended); carry = bit WIDTH.
//    ovf = signed overflow of A+B.
//   0001 SUB: ALU_OUT[W-1:0] = A-B mod 2^W, upper bits 0; carry = (A<B);
//    ovf = signed overflow of A-B.
//   0010 MUL: ALU_OUT = A*B, full 2W bits.
//   0011 DIV: ALU_OUT = {remainder, quotient}.
//    B=0 gives {A, all-ones}, err=1, latency 1, with no DIV state entered.
//   0100..0111: AND, OR, NAND, NOR (W bits, upper bits 0).
//   1000 NOP->0, 1001 EQ->1 if A==B else 0, 1010 GT->2 if A>B else 0, 1011 LT->3 if A<B else 0.
//   1100 A>>1, 1101 A<<1, 1110 B>>1, 1111 B<<1.
//    Shifts are logical, W bits, and the shifted-out bit is dropped.
//  carry and ovf are 0 for every opcode other than ADD/SUB.
//  err is 0 for every case except divide-by-zero and DIV with DIV_EN=0.
//  zero is evaluated on the loaded ALU_OUT for every op.
//  Operands and opcode are captured at accept; input changes during DIV have no effect.
// TESTING  (WIDTH=8, DIV_EN=1)
//  ADD A=F0 B=20, out_ready=1 -> next cycle out_valid=1, ALU_OUT=0110, carry=1, ovf=0, zero=0.
//  SUB A=03 B=05 -> ALU_OUT=00FE, carry=1, ovf=0.
//   SUB A=80 B=01 -> ALU_OUT=007F, ovf=1.
//  DIV A=200 B=7 -> in_ready=0 for 8 cycles; out_valid on cycle 9 with ALU_OUT=041C.
//   Then DIV A=5 B=0 -> 1 cycle later ALU_OUT=05FF, err=1.
//  Backpressure: out_ready=0, issue GT 9,3 then hold in_valid with EQ 4,4.
//   -> ALU_OUT=0002 held and in_ready=0.
//   Raise out_ready -> same edge accepts EQ; next cycle ALU_OUT=0001, out_valid=1.
//  Assert RST 3 cycles into DIV 255/1 -> out_valid=0, all outputs 0.
//   After release, MUL FF*FF -> ALU_OUT=FE01 after 1 cycle.
//  Random opcode/operand stream with random out_ready checked against the reference model.
//   No result is lost or duplicated, and outputs are stable under stall.

Source files
------------

// File: rtl/alu_pipe_hs_if.sv
// alu_pipe_hs_if
//   Handshake bundle for alu_pipe_hs: operand/opcode input channel and
//   result/flag output channel.
//   Handshake rule for both channels: a transfer happens on the rising
//   clock edge where valid and ready are both 1. The sender holds its
//   payload stable while valid=1 and ready=0. Ready never depends on
//   the valid of the same channel.
//   Modports:
//     master - command source / result consumer
//              (drives in_valid, A, B, ALU_FUN, out_ready)
//     slave  - the ALU (drives in_ready, out_valid, ALU_OUT, carry, ovf,
//              zero, err)
interface alu_pipe_hs_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [3:0]         ALU_FUN;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               carry;
    logic               ovf;
    logic               zero;
    logic               err;

    modport master (
        output in_valid, A, B, ALU_FUN, out_ready,
        input  in_ready, out_valid, ALU_OUT, carry, ovf, zero, err
    );

    modport slave (
        input  in_valid, A, B, ALU_FUN, out_ready,
        output in_ready, out_valid, ALU_OUT, carry, ovf, zero, err
    );
endinterface

// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs
//   WIDTH-bit ALU with valid/ready on input and output, a one-deep
//   registered result (2*WIDTH bits plus carry/ovf/zero/err flags) and an
//   iterative restoring shift-subtract divider.
//   Ports:
//     CLK        clock, all state on rising edge
//     RST        asynchronous active-high reset
//     bus        alu_pipe_hs_if.slave (input and output channels)
//     state_dbg  FSM state for observation: 0 = IDLE, 1 = DIV
//   All single-cycle ops load the result register on the accept edge.
//   DIV with a non-zero divisor enters the DIV state and loads the result
//   WIDTH edges later; in_ready is held low throughout.
module alu_pipe_hs #(
    parameter int WIDTH  = 8,
    parameter bit DIV_EN = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    alu_pipe_hs_if.slave  bus,
    output logic          state_dbg
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [RW-1:0]    result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // single-cycle datapath
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [RW-1:0]    prod;
    logic [RW-1:0]    op_res;
    logic             op_carry, op_ovf, op_err, div_start;

    // divider step
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    logic in_ready, accept;

    // RST gates in_ready so nothing is accepted while reset is held.
    assign in_ready = !RST && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        sum       = {1'b0, bus.A} + {1'b0, bus.B};
        diff      = bus.A - bus.B;
        prod      = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
        op_res    = '0;
        op_carry  = 1'b0;
        op_ovf    = 1'b0;
        op_err    = 1'b0;
        div_start = 1'b0;
        case (bus.ALU_FUN)
            4'b0000: begin
                op_res   = {{(WIDTH-1){1'b0}}, sum};
                op_carry = sum[WIDTH];
                // operands of equal sign giving a result of the other sign
                op_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                           (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0001: begin
                op_res   = {{WIDTH{1'b0}}, diff};
                op_carry = (bus.A < bus.B);
                op_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                           (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0010: op_res = prod;
            4'b0011: begin
                if (!DIV_EN) begin
                    op_err = 1'b1;
                end else if (bus.B == '0) begin
                    op_res = {bus.A, {WIDTH{1'b1}}};
                    op_err = 1'b1;
                end else begin
                    div_start = 1'b1;
                end
            end
            4'b0100: op_res = {{WIDTH{1'b0}}, bus.A & bus.B};
            4'b0101: op_res = {{WIDTH{1'b0}}, bus.A | bus.B};
            4'b0110: op_res = {{WIDTH{1'b0}}, ~(bus.A & bus.B)};
            4'b0111: op_res = {{WIDTH{1'b0}}, ~(bus.A | bus.B)};
            4'b1000: op_res = '0;
            4'b1001: op_res = (bus.A == bus.B) ? RW'(1) : '0;
            4'b1010: op_res = (bus.A > bus.B)  ? RW'(2) : '0;
            4'b1011: op_res = (bus.A < bus.B)  ? RW'(3) : '0;
            4'b1100: op_res = {{WIDTH{1'b0}}, bus.A >> 1};
            4'b1101: op_res = {{WIDTH{1'b0}}, bus.A << 1};
            4'b1110: op_res = {{WIDTH{1'b0}}, bus.B >> 1};
            default: op_res = {{WIDTH{1'b0}}, bus.B << 1};
        endcase
    end

    // One restoring iteration: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits. The
    // remainder entering a step is below the divisor, so after the shift
    // it needs one extra bit, and after the conditional subtract it fits
    // back into WIDTH bits.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        rem_nx = rem_sh[WIDTH-1:0];
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_nx    = rem_sh[WIDTH-1:0] - dvs_q;
            quo_nx[0] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        err_d       = err_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (div_start) begin
                        state_d = DIV;
                        rem_d   = '0;
                        quo_d   = bus.A;
                        dvs_d   = bus.B;
                        cnt_d   = '0;
                    end else begin
                        result_d    = op_res;
                        carry_d     = op_carry;
                        ovf_d       = op_ovf;
                        err_d       = op_err;
                        zero_d      = (op_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    result_d    = {rem_nx, quo_nx};
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    err_d       = 1'b0;
                    zero_d      = ({rem_nx, quo_nx} == '0);
                    out_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.ALU_OUT   = result_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign state_dbg     = (state_q == DIV);
endmodule
